run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
//  Parametrised successor to the fixed 4-in-a-row 0/1 sequence detector FSM.
//  Counts consecutive equal samples on a serial input w and flags a run of
//  RUN_ZERO zeros or RUN_ONE ones. Adds a sample-valid qualifier, a saturating
//  run-length output, a one-cycle detect pulse and a saturating detection counter.
//  Sits in the lab serial-input path.
//  Feeds LEDs/status logic exactly as the one-hot detector did.
// PARAMETERS
//  RUN_ZERO  4  zeros in a row needed to assert z_zero (1..2**CNT_W-1)
//  RUN_ONE   4  ones in a row needed to assert z_one (1..2**CNT_W-1)
//  CNT_W     8  width of run_len and det_count; both saturate at 2**CNT_W-1
// PORTS
//  sys_clock     in   1      single clock, all logic on posedge
//  sys_reset     in   1      synchronous, active-high reset
//  w             in   1      serial data bit
//  w_valid       in   1      w is sampled only when 1
//  clear_cnt     in   1      synchronous clear of det_count
//  z             out  1      z_zero | z_one
//  z_zero        out  1      current run is zeros and run_len >= RUN_ZERO
//  z_one         out  1      current run is ones and run_len >= RUN_ONE
//  detect_pulse  out  1      1 for one cycle when run_len reaches threshold
//  run_bit       out  1      bit value of current run
//  run_len       out  CNT_W  length of current run, saturating
//  det_count     out  CNT_W  number of detect_pulse events, saturating
//  state_oh      out  3      one-hot state {ONE_RUN,ZERO_RUN,IDLE}
// BEHAVIOUR
//  - All outputs registered, driven from flops (no comb path from w to outputs).
//  - Reset: sys_reset=1 at posedge -> state IDLE (state_oh=3'b001).
//    run_len=0, run_bit=0, z/z_zero/z_one/detect_pulse=0, det_count=0.
//    Reset overrides every other input.
//  - FSM states:
//    - IDLE: no run seen yet.
//    - ZERO_RUN: current run is zeros.
//    - ONE_RUN: current run is ones.
//  - Valid sample (w_valid=1) in IDLE or with w != run_bit:
//    - state <= w ? ONE_RUN : ZERO_RUN; run_bit <= w; run_len <= 1.
//  - Valid sample with w == run_bit (non-IDLE): run_len <= min(run_len+1, 2**CNT_W-1).
//  - w_valid=0: state, run_bit, run_len, z* held; detect_pulse <= 0.
//  - Latency: z* and detect_pulse update on the same edge that samples the
//    threshold-th bit, i.e. visible the cycle after that sample is presented.
//  - z_zero/z_one computed from the next-state values; stay high for the whole
//    run, including while run_len is saturated. Both drop on the first opposite bit.
//  - detect_pulse <= 1 only when a valid sample makes the new run_len equal to the
//    run's threshold. Exactly one pulse per run, never repeated at saturation.
//    With threshold 1, every run start pulses.
//  - det_count: +1 (saturating) on each detect_pulse set.
//    clear_cnt=1 -> det_count <= 0; clear wins over a simultaneous pulse (result 0).
//  - A reset mid-run discards the run; the next valid sample starts run_len=1.
//  - Illegal state encodings recover to IDLE on the next edge.
// TESTING
//  1. Reset, then w=0 valid x4 -> after 4th edge: z=z_zero=1, run_len=4,
//     detect_pulse=1 for 1 cycle, det_count=1.
//  2. w=0,0,0,1,1,1,1 -> z_zero never 1; z_one=1 after 7th edge, run_bit=1, run_len=4.
//  3. w=0 valid, then w_valid=0 for 3 cycles (w toggling), then w=0 valid x3 ->
//     outputs held during gaps; detect on the 4th valid sample only.
//  4. 300 consecutive valid zeros -> run_len sticks at 255, z stays 1,
//     exactly one detect_pulse, det_count=1.
//  5. 3 zeros, sys_reset=1 one cycle, 1 zero -> run_len=1, z=0, det_count=0.
//  6. clear_cnt=1 on the edge of the 4th zero -> detect_pulse=1, det_count=0;
//     next run of 4 ones -> det_count=1.

Source files
------------

// File: rtl/run_length_detector_if.sv
// Signal bundle for run_length_detector: a qualified serial sample in, registered run status out.
// w is accepted only in cycles where w_valid=1; there is no ready, the detector takes every valid sample.
interface run_length_detector_if #(
    parameter int CNT_W = 8
);
    logic             w;
    logic             w_valid;
    logic             clear_cnt;
    logic             z;
    logic             z_zero;
    logic             z_one;
    logic             detect_pulse;
    logic             run_bit;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] det_count;
    logic [2:0]       state_oh;

    modport master (
        output w, w_valid, clear_cnt,
        input  z, z_zero, z_one, detect_pulse, run_bit, run_len, det_count, state_oh
    );

    modport slave (
        input  w, w_valid, clear_cnt,
        output z, z_zero, z_one, detect_pulse, run_bit, run_len, det_count, state_oh
    );
endinterface

// File: rtl/run_length_detector.sv
// Run-length detector: tracks consecutive equal valid samples of w and flags
// runs of RUN_ZERO zeros or RUN_ONE ones; every output comes straight from a flop.
module run_length_detector #(
    parameter int RUN_ZERO = 4,
    parameter int RUN_ONE  = 4,
    parameter int CNT_W    = 8
) (
    input logic                  sys_clock,
    input logic                  sys_reset,
    run_length_detector_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        ZERO_RUN = 3'b010,
        ONE_RUN  = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] LEN_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THR_ZERO = CNT_W'(RUN_ZERO);
    localparam logic [CNT_W-1:0] THR_ONE  = CNT_W'(RUN_ONE);

    state_t           state_q, state_d;
    logic             run_bit_q, run_bit_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] det_count_q, det_count_d;
    logic             detect_q, detect_d;
    logic             z_zero_q, z_zero_d;
    logic             z_one_q, z_one_d;
    logic             z_q, z_d;
    logic             grew;
    logic [CNT_W-1:0] thr;

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            state_q     <= IDLE;
            run_bit_q   <= 1'b0;
            run_len_q   <= '0;
            det_count_q <= '0;
            detect_q    <= 1'b0;
            z_zero_q    <= 1'b0;
            z_one_q     <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_bit_q   <= run_bit_d;
            run_len_q   <= run_len_d;
            det_count_q <= det_count_d;
            detect_q    <= detect_d;
            z_zero_q    <= z_zero_d;
            z_one_q     <= z_one_d;
            z_q         <= z_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_bit_d   = run_bit_q;
        run_len_d   = run_len_q;
        det_count_d = det_count_q;
        grew        = 1'b0;

        case (state_q)
            IDLE, ZERO_RUN, ONE_RUN: begin
                if (bus.w_valid) begin
                    if (state_q == IDLE || bus.w != run_bit_q) begin
                        state_d   = bus.w ? ONE_RUN : ZERO_RUN;
                        run_bit_d = bus.w;
                        run_len_d = CNT_W'(1);
                        grew      = 1'b1;
                    end else if (run_len_q != LEN_MAX) begin
                        run_len_d = run_len_q + 1'b1;
                        grew      = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                run_bit_d = 1'b0;
                run_len_d = '0;
            end
        endcase

        // Pulse only when the length actually steps onto the threshold, so a saturated run never re-fires.
        thr      = run_bit_d ? THR_ONE : THR_ZERO;
        detect_d = grew && (run_len_d == thr);
        z_zero_d = (state_d == ZERO_RUN) && (run_len_d >= THR_ZERO);
        z_one_d  = (state_d == ONE_RUN) && (run_len_d >= THR_ONE);
        z_d      = z_zero_d | z_one_d;

        if (bus.clear_cnt) begin
            det_count_d = '0;
        end else if (detect_d && det_count_q != LEN_MAX) begin
            det_count_d = det_count_q + 1'b1;
        end
    end

    assign bus.z            = z_q;
    assign bus.z_zero       = z_zero_q;
    assign bus.z_one        = z_one_q;
    assign bus.detect_pulse = detect_q;
    assign bus.run_bit      = run_bit_q;
    assign bus.run_len      = run_len_q;
    assign bus.det_count    = det_count_q;
    assign bus.state_oh     = state_q;
endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector with hand-computed expectations.
module tb_run_length_detector;
    logic sys_clock = 1'b0;
    logic sys_reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    run_length_detector_if #(.CNT_W(8)) bus ();

    run_length_detector #(
        .RUN_ZERO(4),
        .RUN_ONE (4),
        .CNT_W   (8)
    ) dut (
        .sys_clock(sys_clock),
        .sys_reset(sys_reset),
        .bus      (bus.slave)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic step(input logic w, input logic valid, input logic clr);
        bus.w         = w;
        bus.w_valid   = valid;
        bus.clear_cnt = clr;
        @(posedge sys_clock);
        #1;
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        sys_reset = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        sys_reset = 1'b0;
        checks++;
        if (bus.state_oh !== 3'b001) begin errors++; $display("FAIL reset_state got=%b exp=001", bus.state_oh); end
        checks++;
        if ({bus.z, bus.z_zero, bus.z_one, bus.detect_pulse, bus.run_bit} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {bus.z, bus.z_zero, bus.z_one, bus.detect_pulse, bus.run_bit});
        end
        checks++;
        if (bus.run_len !== 8'd0 || bus.det_count !== 8'd0) begin
            errors++; $display("FAIL reset_counts run_len=%0d det_count=%0d exp=0,0", bus.run_len, bus.det_count);
        end
    endtask

    task automatic test_detect_zeros();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.run_len !== 8'(i) || bus.z !== 1'b0 || bus.detect_pulse !== 1'b0) begin
                errors++; $display("FAIL zeros_pre%0d run_len=%0d z=%b det=%b exp=%0d,0,0", i, bus.run_len, bus.z, bus.detect_pulse, i);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.z !== 1'b1 || bus.z_zero !== 1'b1 || bus.z_one !== 1'b0 || bus.run_len !== 8'd4) begin
            errors++; $display("FAIL zeros_hit z=%b z_zero=%b z_one=%b run_len=%0d exp=1,1,0,4", bus.z, bus.z_zero, bus.z_one, bus.run_len);
        end
        checks++;
        if (bus.detect_pulse !== 1'b1 || bus.det_count !== 8'd1 || bus.state_oh !== 3'b010) begin
            errors++; $display("FAIL zeros_pulse det=%b cnt=%0d st=%b exp=1,1,010", bus.detect_pulse, bus.det_count, bus.state_oh);
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.detect_pulse !== 1'b0 || bus.z !== 1'b1 || bus.det_count !== 8'd1) begin
            errors++; $display("FAIL zeros_after det=%b z=%b cnt=%0d exp=0,1,1", bus.detect_pulse, bus.z, bus.det_count);
        end
    endtask

    task automatic test_run_switch();
        logic [6:0] seq;
        seq = 7'b1111000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(seq[i], 1'b1, 1'b0);
            checks++;
            if (bus.z_zero !== 1'b0) begin errors++; $display("FAIL switch_zz%0d got=%b exp=0", i, bus.z_zero); end
            if (i == 3) begin
                checks++;
                if (bus.run_len !== 8'd1 || bus.run_bit !== 1'b1 || bus.state_oh !== 3'b100) begin
                    errors++; $display("FAIL switch_first1 run_len=%0d bit=%b st=%b exp=1,1,100", bus.run_len, bus.run_bit, bus.state_oh);
                end
            end
        end
        checks++;
        if (bus.z_one !== 1'b1 || bus.z !== 1'b1 || bus.run_bit !== 1'b1 || bus.run_len !== 8'd4 || bus.detect_pulse !== 1'b1) begin
            errors++; $display("FAIL switch_ones z_one=%b z=%b bit=%b len=%0d det=%b exp=1,1,1,4,1",
                               bus.z_one, bus.z, bus.run_bit, bus.run_len, bus.detect_pulse);
        end
    endtask

    task automatic test_valid_gap();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus.run_len !== 8'd1 || bus.state_oh !== 3'b010 || bus.detect_pulse !== 1'b0 || bus.z !== 1'b0) begin
                errors++; $display("FAIL gap_hold%0d len=%0d st=%b det=%b z=%b exp=1,010,0,0", i, bus.run_len, bus.state_oh, bus.detect_pulse, bus.z);
            end
        end
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++;
            if (bus.run_len !== 8'(i) || bus.detect_pulse !== (i == 4) || bus.z !== (i == 4)) begin
                errors++; $display("FAIL gap_run%0d len=%0d det=%b z=%b exp=%0d,%b,%b", i, bus.run_len, bus.detect_pulse, bus.z, i, i == 4, i == 4);
            end
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (bus.detect_pulse === 1'b1) pulses++;
            if (i >= 4) begin
                checks++;
                if (bus.z !== 1'b1) begin errors++; $display("FAIL sat_z%0d got=%b exp=1", i, bus.z); end
            end
        end
        checks++;
        if (bus.run_len !== 8'd255) begin errors++; $display("FAIL sat_len got=%0d exp=255", bus.run_len); end
        checks++;
        if (pulses != 1 || bus.det_count !== 8'd1) begin
            errors++; $display("FAIL sat_pulses pulses=%0d cnt=%0d exp=1,1", pulses, bus.det_count);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        sys_reset = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        sys_reset = 1'b0;
        checks++;
        if (bus.run_len !== 8'd0 || bus.state_oh !== 3'b001) begin
            errors++; $display("FAIL midrst_clear len=%0d st=%b exp=0,001", bus.run_len, bus.state_oh);
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.run_len !== 8'd1 || bus.z !== 1'b0 || bus.det_count !== 8'd0 || bus.detect_pulse !== 1'b0) begin
            errors++; $display("FAIL midrst_restart len=%0d z=%b cnt=%0d det=%b exp=1,0,0,0", bus.run_len, bus.z, bus.det_count, bus.detect_pulse);
        end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.detect_pulse !== 1'b1 || bus.det_count !== 8'd0) begin
            errors++; $display("FAIL clear_wins det=%b cnt=%0d exp=1,0", bus.detect_pulse, bus.det_count);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.det_count !== 8'd1 || bus.z_one !== 1'b1 || bus.z_zero !== 1'b0) begin
            errors++; $display("FAIL clear_next cnt=%0d z_one=%b z_zero=%b exp=1,1,0", bus.det_count, bus.z_one, bus.z_zero);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.det_count !== 8'd0 || bus.z_one !== 1'b1) begin
            errors++; $display("FAIL clear_idle cnt=%0d z_one=%b exp=0,1", bus.det_count, bus.z_one);
        end
    endtask

    initial begin
        bus.w         = 1'b0;
        bus.w_valid   = 1'b0;
        bus.clear_cnt = 1'b0;
        test_reset();
        test_detect_zeros();
        test_run_switch();
        test_valid_gap();
        test_saturation();
        test_reset_mid_run();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
